// File: rtl/clk_step_ctrl_if.sv
// Board-side controls and CPU-side clock enables of the clock sequencer.
// master = board/CPU environment, slave = clk_step_ctrl.
interface clk_step_ctrl_if;
  logic        run_sw;
  logic        step_btn;
  logic        sw_rst;
  logic        cpu_ce;
  logic        mem_ce;
  logic        cpu_rst;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  modport master (
    output run_sw, step_btn, sw_rst,
    input  cpu_ce, mem_ce, cpu_rst, state, cycle_cnt
  );

  modport slave (
    input  run_sw, step_btn, sw_rst,
    output cpu_ce, mem_ce, cpu_rst, state, cycle_cnt
  );
endinterface

// File: rtl/clk_step_ctrl.sv
// CPU clock sequencer: paced mem_ce/cpu_ce pulses with run, halt, debounced single-step
// and a reset phase that issues RST_HOLD CPU cycles with cpu_rst asserted.
module clk_step_ctrl #(
  parameter int unsigned DIV_RUN    = 500000,
  parameter int unsigned CW         = 24,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned RST_HOLD   = 3
) (
  input  logic           clkin,
  input  logic           rst_n,
  clk_step_ctrl_if.slave bus
);
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HW = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {
    ST_RST  = 2'b00,
    ST_HALT = 2'b01,
    ST_RUN  = 2'b10,
    ST_STEP = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    run_sync_q, step_sync_q, rst_sync_q;
  logic          deb_lvl_q, deb_lvl_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CW-1:0] counter_q, counter_d;
  logic          phase_q, phase_d;
  logic          mem_ce_q, mem_ce_d;
  logic          cpu_ce_q, cpu_ce_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          stop_q, stop_d;
  logic [31:0]   cyc_q, cyc_d;
  logic          run_s, step_s, sw_s;
  logic          step_req;
  logic          wrap;

  assign run_s  = run_sync_q[1];
  assign step_s = step_sync_q[1];
  assign sw_s   = rst_sync_q[1];
  assign wrap   = (counter_q == CW'(DIV_RUN - 1));

  // The step request fires on the same edge the accepted level rises.
  always_comb begin
    deb_lvl_d = deb_lvl_q;
    deb_cnt_d = '0;
    step_req  = 1'b0;
    if (step_s != deb_lvl_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        deb_lvl_d = step_s;
        step_req  = step_s;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stop_d    = stop_q;
    cyc_d     = cyc_q;
    counter_d = '0;
    phase_d   = 1'b0;
    mem_ce_d  = 1'b0;
    cpu_ce_d  = 1'b0;

    case (state_q)
      ST_RST: begin
        if (cpu_ce_q) begin
          hold_d = hold_q + HW'(1);
          if (hold_q == HW'(RST_HOLD - 1)) begin
            state_d = run_s ? ST_RUN : ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (run_s) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        // A halt request is remembered and only acted on at the cpu_ce ending a CPU cycle.
        if (!run_s) begin
          stop_d = 1'b1;
        end
        if (cpu_ce_q && (stop_q || !run_s)) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        if (cpu_ce_q) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_RST;
    endcase

    if (cpu_ce_q && state_q != ST_RST) begin
      cyc_d = cyc_q + 32'd1;
    end

    if (sw_s) begin
      state_d = ST_RST;
      hold_d  = '0;
      cyc_d   = '0;
    end

    if (state_d != ST_RUN) begin
      stop_d = 1'b0;
    end
    if (state_d != ST_RST) begin
      hold_d = '0;
    end

    // Pacing is frozen at zero in HALT and on the edge entering it, so every start is aligned.
    if (!sw_s && state_q != ST_HALT && state_d != ST_HALT) begin
      counter_d = wrap ? '0 : counter_q + CW'(1);
      phase_d   = wrap ? ~phase_q : phase_q;
      mem_ce_d  = wrap & ~phase_q;
      cpu_ce_d  = wrap & phase_q;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      run_sync_q  <= '0;
      step_sync_q <= '0;
      rst_sync_q  <= '0;
      deb_lvl_q   <= 1'b0;
      deb_cnt_q   <= '0;
      state_q     <= ST_RST;
      counter_q   <= '0;
      phase_q     <= 1'b0;
      mem_ce_q    <= 1'b0;
      cpu_ce_q    <= 1'b0;
      hold_q      <= '0;
      stop_q      <= 1'b0;
      cyc_q       <= '0;
    end else begin
      run_sync_q  <= {run_sync_q[0], bus.run_sw};
      step_sync_q <= {step_sync_q[0], bus.step_btn};
      rst_sync_q  <= {rst_sync_q[0], bus.sw_rst};
      deb_lvl_q   <= deb_lvl_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      counter_q   <= counter_d;
      phase_q     <= phase_d;
      mem_ce_q    <= mem_ce_d;
      cpu_ce_q    <= cpu_ce_d;
      hold_q      <= hold_d;
      stop_q      <= stop_d;
      cyc_q       <= cyc_d;
    end
  end

  assign bus.cpu_ce    = cpu_ce_q;
  assign bus.mem_ce    = mem_ce_q;
  assign bus.cpu_rst   = (state_q == ST_RST);
  assign bus.state     = state_q;
  assign bus.cycle_cnt = cyc_q;
endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl with small pacing/debounce parameters; expected pulse
// positions are derived arithmetically from the edge count and the parameters.
module tb_clk_step_ctrl;
  localparam int DIV  = 4;
  localparam int DEB  = 8;
  localparam int HOLD = 2;
  localparam int P    = 2 * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_step_ctrl_if bus();

  clk_step_ctrl #(
    .DIV_RUN   (DIV),
    .CW        (8),
    .DEB_CYCLES(DEB),
    .RST_HOLD  (HOLD)
  ) dut (
    .clkin(clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_asrt  = 0;
  int n_fail  = 0;
  int n_mem   = 0;
  int n_cpu   = 0;
  int n_both  = 0;
  int retired = 0;

  // Scoreboard of observed pulses; retired counts CPU cycles outside reset.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.mem_ce && bus.cpu_ce) n_both++;
      if (bus.mem_ce) n_mem++;
      if (bus.cpu_ce) begin
        n_cpu++;
        if (!bus.cpu_rst) retired++;
      end
    end
  end

  task automatic test_reset();
    logic [4:0] exp_v, got_v;
    int last;
    bus.run_sw = 1'b0; bus.step_btn = 1'b0; bus.sw_rst = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got_v = {bus.mem_ce, bus.cpu_ce, bus.cpu_rst, bus.state};
    n_asrt++;
    if (got_v !== 5'b00100) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", got_v, 5'b00100);
    end
    n_asrt++;
    if (bus.cycle_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cycle_cnt: got %0d expected 0", bus.cycle_cnt);
    end
    rst_n = 1'b1;
    last = P * HOLD;
    for (int n = 1; n <= 4 * P; n++) begin
      @(negedge clk);
      exp_v[4]   = (n % P == DIV) && (n <= last);
      exp_v[3]   = (n % P == 0) && (n <= last);
      exp_v[2]   = (n <= last);
      exp_v[1:0] = (n <= last) ? 2'b00 : 2'b01;
      got_v = {bus.mem_ce, bus.cpu_ce, bus.cpu_rst, bus.state};
      n_asrt++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL rst_hold_edge%0d {mem,cpu,rst,state}: got %b expected %b", n, got_v, exp_v);
      end
    end
    n_asrt++;
    if (bus.cycle_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_hold_not_counted: got %0d expected 0", bus.cycle_cnt);
    end
  endtask

  task automatic test_run();
    int lat, gap;
    bus.run_sw = 1'b1;
    lat = 0;
    while (bus.state !== 2'b10 && lat < 10) begin
      @(negedge clk); lat++;
    end
    n_asrt++;
    if (lat != 3) begin
      n_fail++; $display("FAIL run_entry_latency: got %0d expected 3", lat);
    end
    for (int e = 0; e < 20; e++) begin
      gap = 0;
      do begin
        @(negedge clk); gap++;
      end while (!(bus.mem_ce || bus.cpu_ce) && gap < 2 * P);
      n_asrt++;
      if (gap != DIV || bus.cpu_ce !== logic'(e % 2) || bus.mem_ce !== logic'(1 - e % 2)) begin
        n_fail++;
        $display("FAIL run_pulse%0d: gap %0d mem %b cpu %b, expected gap %0d mem %0d cpu %0d",
                 e, gap, bus.mem_ce, bus.cpu_ce, DIV, 1 - e % 2, e % 2);
      end
    end
    @(negedge clk);
    n_asrt++;
    if (bus.cycle_cnt !== 32'd10) begin
      n_fail++; $display("FAIL run_cycle_cnt: got %0d expected 10", bus.cycle_cnt);
    end
  endtask

  task automatic test_stop();
    int gap, k, quiet, m0, c0;
    gap = 0;
    do begin
      @(negedge clk); gap++;
    end while (!bus.mem_ce && gap < 2 * P);
    k = $urandom_range(0, 1);
    repeat (k) @(negedge clk);
    bus.run_sw = 1'b0;
    gap = k;
    do begin
      @(negedge clk); gap++;
    end while (!bus.cpu_ce && gap < 2 * P);
    n_asrt++;
    if (gap != DIV) begin
      n_fail++; $display("FAIL stop_last_cpu_ce: got distance %0d expected %0d", gap, DIV);
    end
    @(negedge clk);
    n_asrt++;
    if (bus.state !== 2'b01) begin
      n_fail++; $display("FAIL stop_state: got %b expected 01", bus.state);
    end
    m0 = n_mem; c0 = n_cpu; quiet = 0;
    repeat (3 * P) begin
      @(negedge clk);
      if (bus.state !== 2'b01) quiet++;
    end
    n_asrt++;
    if (n_mem != m0 || n_cpu != c0 || quiet != 0) begin
      n_fail++; $display("FAIL stop_quiet: got %0d extra ce, %0d non-halt samples, expected 0/0",
                         (n_mem - m0) + (n_cpu - c0), quiet);
    end
    n_asrt++;
    if (bus.cycle_cnt !== 32'd11 || retired != 11) begin
      n_fail++; $display("FAIL stop_cycle_cnt: got %0d (seen %0d) expected 11", bus.cycle_cnt, retired);
    end
  endtask

  task automatic test_step();
    int len, m0, c0, r0, wt;
    logic [3:0] exp_v, got_v;
    for (int g = 0; g < 3; g++) begin
      len = $urandom_range(3, 7);
      m0 = n_mem; c0 = n_cpu;
      bus.step_btn = 1'b1;
      repeat (len) @(negedge clk);
      bus.step_btn = 1'b0;
      repeat (DEB + 6) @(negedge clk);
      n_asrt++;
      if (bus.state !== 2'b01 || n_mem != m0 || n_cpu != c0) begin
        n_fail++; $display("FAIL glitch%0d_len%0d: got state %b ce %0d expected state 01 ce 0",
                           g, len, bus.state, (n_mem - m0) + (n_cpu - c0));
      end
    end
    m0 = n_mem; c0 = n_cpu; r0 = retired;
    bus.step_btn = 1'b1;
    wt = 0;
    while (bus.state !== 2'b11 && wt < DEB + 8) begin
      @(negedge clk); wt++;
    end
    n_asrt++;
    if (bus.state !== 2'b11) begin
      n_fail++; $display("FAIL step_entry: got state %b expected 11", bus.state);
    end
    for (int i = 1; i <= P + 1; i++) begin
      @(negedge clk);
      exp_v = {logic'(i == DIV), logic'(i == P), (i <= P) ? 2'b11 : 2'b01};
      got_v = {bus.mem_ce, bus.cpu_ce, bus.state};
      n_asrt++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL step_cycle%0d {mem,cpu,state}: got %b expected %b", i, got_v, exp_v);
      end
    end
    repeat (2 * DEB) @(negedge clk);
    bus.step_btn = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    n_asrt++;
    if (n_mem != m0 + 1 || n_cpu != c0 + 1 || bus.state !== 2'b01) begin
      n_fail++; $display("FAIL step_no_repeat: got mem %0d cpu %0d state %b expected 1 1 01",
                         n_mem - m0, n_cpu - c0, bus.state);
    end
    n_asrt++;
    if (bus.cycle_cnt !== 32'(r0 + 1)) begin
      n_fail++; $display("FAIL step_cycle_cnt: got %0d expected %0d", bus.cycle_cnt, r0 + 1);
    end
  endtask

  task automatic test_sw_rst();
    int wt, base, bad, m, last;
    logic [4:0] exp_v, got_v;
    bus.run_sw = 1'b1;
    wt = 0;
    while (bus.state !== 2'b10 && wt < 10) begin
      @(negedge clk); wt++;
    end
    repeat ($urandom_range(1, P - 1)) @(negedge clk);
    bus.sw_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_asrt++;
    if (bus.state !== 2'b00 || bus.cpu_rst !== 1'b1 || bus.cycle_cnt !== 32'd0) begin
      n_fail++; $display("FAIL swrst_enter: got state %b cpu_rst %b cnt %0d expected 00 1 0",
                         bus.state, bus.cpu_rst, bus.cycle_cnt);
    end
    base = retired;
    bus.run_sw = 1'b0;
    bad = 0;
    repeat ($urandom_range(4, 10)) begin
      @(negedge clk);
      if (bus.state !== 2'b00 || bus.mem_ce || bus.cpu_ce) bad++;
    end
    n_asrt++;
    if (bad != 0) begin
      n_fail++; $display("FAIL swrst_held: got %0d active samples expected 0", bad);
    end
    bus.sw_rst = 1'b0;
    last = P * HOLD;
    for (int n = 1; n <= 4 * P; n++) begin
      @(negedge clk);
      m = n - 2;
      exp_v[4]   = (m > 0) && (m % P == DIV) && (m <= last);
      exp_v[3]   = (m > 0) && (m % P == 0) && (m <= last);
      exp_v[2]   = (m <= last);
      exp_v[1:0] = (m <= last) ? 2'b00 : 2'b01;
      got_v = {bus.mem_ce, bus.cpu_ce, bus.cpu_rst, bus.state};
      n_asrt++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL swrst_release_edge%0d {mem,cpu,rst,state}: got %b expected %b", n, got_v, exp_v);
      end
    end
    n_asrt++;
    if (bus.cycle_cnt !== 32'(retired - base)) begin
      n_fail++; $display("FAIL swrst_cycle_cnt: got %0d expected %0d", bus.cycle_cnt, retired - base);
    end
  endtask

  task automatic test_async_reset();
    int wt, c0;
    logic [4:0] got_v;
    bus.step_btn = 1'b1;
    wt = 0;
    while (bus.state !== 2'b11 && wt < DEB + 8) begin
      @(negedge clk); wt++;
    end
    n_asrt++;
    if (bus.state !== 2'b11) begin
      n_fail++; $display("FAIL areset_step_entry: got state %b expected 11", bus.state);
    end
    c0 = n_cpu;
    repeat ($urandom_range(1, P - 2)) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got_v = {bus.mem_ce, bus.cpu_ce, bus.cpu_rst, bus.state};
    n_asrt++;
    if (got_v !== 5'b00100 || bus.cycle_cnt !== 32'd0) begin
      n_fail++; $display("FAIL areset_immediate: got %b cnt %0d expected 00100 cnt 0", got_v, bus.cycle_cnt);
    end
    bus.step_btn = 1'b0;
    repeat (2 * P) @(negedge clk);
    got_v = {bus.mem_ce, bus.cpu_ce, bus.cpu_rst, bus.state};
    n_asrt++;
    if (n_cpu != c0 || got_v !== 5'b00100) begin
      n_fail++; $display("FAIL areset_no_cpu_ce: got %0d cpu_ce outputs %b expected 0 00100", n_cpu - c0, got_v);
    end
  endtask

  initial begin
    bus.run_sw = 1'b0; bus.step_btn = 1'b0; bus.sw_rst = 1'b0;
    test_reset();
    test_run();
    test_stop();
    test_step();
    test_sw_rst();
    test_async_reset();
    n_asrt++;
    if (n_both != 0) begin
      n_fail++; $display("FAIL ce_overlap: got %0d overlapping cycles expected 0", n_both);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
